// File: rtl/hamming_ecc_pkg.sv
// Shared constants and pure helper functions for the Hamming(7,4) code.
// Codeword bit index = 7 - Hamming position, so position 1 is the MSB.
package hamming_ecc_pkg;

   localparam int unsigned CW_W   = 7;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned SYN_W  = 3;

   // Hamming position -> codeword bit index
   localparam int unsigned P1 = 6;
   localparam int unsigned P2 = 5;
   localparam int unsigned P3 = 4;
   localparam int unsigned P4 = 3;
   localparam int unsigned P5 = 2;
   localparam int unsigned P6 = 1;
   localparam int unsigned P7 = 0;

   // Syndrome {s4,s2,s1}; a nonzero value names the erroneous position
   function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
      logic s1, s2, s4;
      s1 = cw[P1] ^ cw[P3] ^ cw[P5] ^ cw[P7];
      s2 = cw[P2] ^ cw[P3] ^ cw[P6] ^ cw[P7];
      s4 = cw[P4] ^ cw[P5] ^ cw[P6] ^ cw[P7];
      return {s4, s2, s1};
   endfunction

   // Data bits {pos3,pos5,pos6,pos7}
   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
      return {cw[P3], cw[P5], cw[P6], cw[P7]};
   endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational syndrome generation and single-bit correction.
module hamming74_syndrome
   import hamming_ecc_pkg::*;
(
   input  logic [CW_W-1:0]  codeword,
   output logic [SYN_W-1:0] syndrome,
   output logic [CW_W-1:0]  corrected
);

   assign syndrome = calc_syndrome(codeword);

   // Invert the position named by the syndrome; zero leaves the word untouched
   always_comb begin
      corrected = codeword;
      for (int unsigned p = 1; p <= CW_W; p++) begin
         if (syndrome == SYN_W'(p)) begin
            corrected[CW_W - p] = ~codeword[CW_W - p];
         end
      end
   end

endmodule

// File: rtl/hamming74_ecc_decoder.sv
// Hamming(7,4) single-error-correcting decoder with a one-cycle output register.
// Data/syndrome/err update every cycle; valid_out only qualifies them.
module hamming74_ecc_decoder
   import hamming_ecc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [CW_W-1:0]   codeword,
   input  logic              valid_in,
   output logic [SYN_W-1:0]  syndrome,
   output logic [DATA_W-1:0] data,
   output logic              valid_out,
   output logic              err
);

   logic [SYN_W-1:0]  syn_d, syn_q;
   logic [CW_W-1:0]   corr;
   logic [DATA_W-1:0] data_d, data_q;
   logic              err_d, err_q;
   logic              valid_q;

   hamming74_syndrome u_syndrome (
      .codeword  (codeword),
      .syndrome  (syn_d),
      .corrected (corr)
   );

   // Next-state: data from the corrected word, err when any syndrome bit is set
   always_comb begin
      data_d = extract_data(corr);
      err_d  = |syn_d;
   end

   // Output register stage, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syn_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         syn_q   <= syn_d;
         data_q  <= data_d;
         err_q   <= err_d;
         valid_q <= valid_in;
      end
   end

   assign syndrome  = syn_q;
   assign data      = data_q;
   assign err       = err_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_hamming74_ecc_decoder.sv
// Self-checking bench: directed vectors, exhaustive single-error sweep and
// randomized back-to-back traffic against a position-arithmetic reference model.
module tb_hamming74_ecc_decoder;

   logic       clk;
   logic       rst;
   logic [6:0] codeword;
   logic       valid_in;
   logic [2:0] syndrome;
   logic [3:0] data;
   logic       valid_out;
   logic       err;

   int total = 0;
   int bad   = 0;

   hamming74_ecc_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .codeword  (codeword),
      .valid_in  (valid_in),
      .syndrome  (syndrome),
      .data      (data),
      .valid_out (valid_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Syndrome = XOR of the position numbers of all set bits
   function automatic void ref_decode(input logic [6:0] cw, output logic [2:0] syn,
                                      output logic [3:0] d);
      int s;
      int pos [8];
      s = 0;
      for (int p = 1; p <= 7; p++) begin
         pos[p] = int'(cw[7 - p]);
         if (pos[p] != 0) s = s ^ p;
      end
      if (s != 0) pos[s] = 1 - pos[s];
      syn = 3'(s);
      d = {pos[3][0], pos[5][0], pos[6][0], pos[7][0]};
   endfunction

   // Place data, then set parity positions so the XOR of set positions is zero
   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] cw;
      int s;
      cw = '0;
      cw[7 - 3] = d[3];
      cw[7 - 5] = d[2];
      cw[7 - 6] = d[1];
      cw[7 - 7] = d[0];
      s = 0;
      if (d[3]) s = s ^ 3;
      if (d[2]) s = s ^ 5;
      if (d[1]) s = s ^ 6;
      if (d[0]) s = s ^ 7;
      if (s[0]) cw[7 - 1] = 1'b1;
      if (s[1]) cw[7 - 2] = 1'b1;
      if (s[2]) cw[7 - 4] = 1'b1;
      return cw;
   endfunction

   task automatic check_outputs(input string tag, input logic [2:0] esyn, input logic [3:0] edata,
                                input logic eerr, input logic evalid);
      check_val({tag, ".syn"}, 32'(syndrome), 32'(esyn));
      check_val({tag, ".data"}, 32'(data), 32'(edata));
      check_val({tag, ".err"}, 32'(err), 32'(eerr));
      check_val({tag, ".valid"}, 32'(valid_out), 32'(evalid));
   endtask

   // Drive at the falling edge, sample 1 time unit after the next rising edge
   task automatic apply(input logic [6:0] cw, input logic vin);
      @(negedge clk);
      codeword = cw;
      valid_in = vin;
      @(posedge clk);
      #1;
   endtask

   logic [6:0] dir_cw   [6] = '{7'b0111100, 7'b1011010, 7'b0100101,
                                7'b1111100, 7'b1011011, 7'b0111110};
   logic [2:0] dir_syn  [6] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b111, 3'b110};
   logic [3:0] dir_data [6] = '{4'b1100, 4'b1010, 4'b0101, 4'b1100, 4'b1010, 4'b1100};

   initial begin
      logic [6:0] cw, prev_cw;
      logic       prev_vin;
      logic [2:0] esyn;
      logic [3:0] edata;

      rst      = 1'b1;
      codeword = 7'b1111111;
      valid_in = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs("reset_hold", 3'b000, 4'b0000, 1'b0, 1'b0);

      rst = 1'b0;
      apply(7'b0000000, 1'b1);
      check_outputs("post_reset", 3'b000, 4'b0000, 1'b0, 1'b1);

      // Load an errored word, then reset between edges
      apply(7'b1111100, 1'b1);
      check_outputs("pre_async", 3'b001, 4'b1100, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_outputs("async_rst", 3'b000, 4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("rst_held", 3'b000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      apply(7'b0000000, 1'b1);
      check_outputs("rst_release", 3'b000, 4'b0000, 1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         apply(dir_cw[i], 1'b1);
         check_outputs($sformatf("dir%0d", i), dir_syn[i], dir_data[i], dir_syn[i] != 0, 1'b1);
      end

      // Every data value, clean and with each single-bit flip
      for (int d = 0; d < 16; d++) begin
         for (int p = 0; p <= 7; p++) begin
            cw = encode(4'(d));
            if (p != 0) cw[7 - p] = ~cw[7 - p];
            apply(cw, 1'b1);
            check_outputs($sformatf("exh_d%0d_p%0d", d, p), 3'(p), 4'(d), p != 0, 1'b1);
         end
      end

      // Back-to-back random words with random valid_in
      @(negedge clk);
      prev_cw  = 7'($urandom);
      prev_vin = 1'($urandom);
      codeword = prev_cw;
      valid_in = prev_vin;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         ref_decode(prev_cw, esyn, edata);
         check_outputs($sformatf("rnd%0d", i), esyn, edata, esyn != 0, prev_vin);
         prev_cw  = 7'($urandom);
         prev_vin = (i < 20) ? 1'(i % 2) : 1'($urandom);
         codeword = prev_cw;
         valid_in = prev_vin;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hamming74_ecc_decoder.md
Name: hamming74_ecc_decoder

Overview:
- Single-error-correcting Hamming(7,4) decoder.
- Takes a 7-bit codeword and computes a 3-bit syndrome.
- Corrects at most one flipped bit and outputs the 4 recovered data bits, registered on the clock.
- Sits on the receive side after channel/memory readout, paired with the team's Hamming(7,4) encoder.

Parameters:
- None. Code is fixed at (7,4); widths come from the shared package.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- codeword  input  7  received codeword; codeword[7-p] holds Hamming position p (p=1..7, MSB = position 1)
- syndrome  output  3  registered syndrome {s4,s2,s1}; nonzero value = erroneous position
- data  output  4  registered corrected data {pos3,pos5,pos6,pos7}, data[3]=pos3
- valid_in  input  1  codeword qualifier; tie high for free-running use
- valid_out  output  1  registered valid_in, aligned with syndrome/data
- err  output  1  registered flag, high when syndrome != 0 (single error corrected)

Behaviour:
- Position map:
  - parity bits at positions 1, 2, 4 (codeword[6], [5], [3])
  - data bits at positions 3, 5, 6, 7 (codeword[4], [2], [1], [0])
- Syndrome, each an XOR over positions:
  - s1 = pos1^pos3^pos5^pos7
  - s2 = pos2^pos3^pos6^pos7
  - s4 = pos4^pos5^pos6^pos7
  - syndrome[0]=s1, syndrome[1]=s2, syndrome[2]=s4
- Correction:
  - if syndrome = k != 0, invert position k, then extract data
  - syndrome 0 means no correction
- Error classes:
  - k in {1,2,4} is a parity-bit error: data unchanged from the raw data bits
  - double errors are not detected; they miscorrect silently (plain Hamming, no overall parity)
- Latency: exactly 1 clock.
  - codeword sampled on rising edge N
  - syndrome/data/err/valid_out reflect it after edge N, until edge N+1
- Gating:
  - syndrome, data and err update every cycle regardless of valid_in
  - valid_out = valid_in delayed 1 cycle; downstream qualifies with valid_out
- Reset:
  - rst high clears syndrome=0, data=0, err=0, valid_out=0 immediately, without waiting for a clock
  - outputs stay cleared while rst is high
  - first post-reset edge loads normally
  - reset asserted mid-stream discards the in-flight sample
- No X propagation: the input is purely combinational to the registers, so the output is fully determined by the sampled codeword.

Decomposition:
- Package hamming_ecc_pkg holds:
  - CW_W=7, DATA_W=4, SYN_W=3
  - position-index constants (P1..P7 mapped to codeword bit indices)
  - pure functions calc_syndrome(codeword) and extract_data(codeword)
- One combinational sub-module, hamming74_syndrome:
  - inputs: codeword
  - outputs: syndrome, corrected codeword
- The top adds only the output register stage.

Test Plan:
- Reset: assert rst asynchronously between edges -> all outputs 0 immediately; deassert with codeword=0000000 -> next edge syndrome=000, data=0000, err=0.
- Valid codewords:
  - 0111100 -> syndrome=000, data=1100, err=0
  - 1011010 -> syndrome=000, data=1010
  - 0100101 -> syndrome=000, data=0101
- Parity-bit error: 1111100 (pos1 flipped from 0111100) -> syndrome=001, data=1100, err=1.
- Data-bit error: 1011011 (pos7 flipped from 1011010) -> syndrome=111, data=1010, err=1; also 0111110 (pos6 flipped) -> syndrome=110, data=1100.
- Exhaustive: all 16 data values encoded, each with no error and each of 7 single-bit flips (128 cases) -> data equals original, syndrome equals flipped position.
- Latency/valid: back-to-back codewords each cycle with valid_in toggling -> outputs lag input by exactly 1 cycle, valid_out mirrors valid_in one cycle later.
